// File: rtl/multiplier_eval_pkg.sv
// multiplier_eval_pkg
// Shared types and helpers for the multiplier sweep controller and its
// latency-matched delay line.
//   sweep_state_t : controller state encoding (IDLE, ISSUE, DRAIN, DONE)
//   LAT_MAX       : largest supported candidate latency
//   prod_width()  : width of a full product of two n-bit operands (2n)
//   count_width() : width of a mismatch counter able to hold 2^(2n) (2n+1)
package multiplier_eval_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } sweep_state_t;

  localparam int LAT_MAX = 7;

  function automatic int prod_width(input int n);
    return 2 * n;
  endfunction

  function automatic int count_width(input int n);
    return 2 * n + 1;
  endfunction

endpackage

// File: rtl/multiplier_sweep_delay.sv
// multiplier_sweep_delay
// LAT-stage pipeline carrying {valid, a, b, golden} alongside the candidate
// multiplier so the golden product arrives in the cycle the candidate's
// product for the same vector does. LAT=0 is a plain wire-through.
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   flush                : synchronous clear of every stage's valid bit
//   in_valid/a/b/golden  : entry of the pipeline
//   out_valid/a/b/golden : exit of the pipeline, LAT cycles later
module multiplier_sweep_delay
  import multiplier_eval_pkg::*;
#(
  parameter int N   = 2,
  parameter int LAT = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  input  logic [N-1:0]             in_a,
  input  logic [N-1:0]             in_b,
  input  logic [prod_width(N)-1:0] in_golden,
  output logic                     out_valid,
  output logic [N-1:0]             out_a,
  output logic [N-1:0]             out_b,
  output logic [prod_width(N)-1:0] out_golden
);

  localparam int PW = prod_width(N);

  if (LAT == 0) begin : g_wire
    assign out_valid  = in_valid;
    assign out_a      = in_a;
    assign out_b      = in_b;
    assign out_golden = in_golden;

    logic unused_ctl;
    assign unused_ctl = ^{clk, rst_n, flush};
  end else begin : g_pipe
    logic [LAT-1:0] valid_q;
    logic [N-1:0]   a_q      [LAT];
    logic [N-1:0]   b_q      [LAT];
    logic [PW-1:0]  golden_q [LAT];

    // NOTE: sequential state is written with non-blocking assignments so
    // every stage samples the previous stage's old value on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q <= '0;
      end else if (flush) begin
        valid_q <= '0;
      end else begin
        valid_q[0] <= in_valid;
        for (int i = 1; i < LAT; i++) valid_q[i] <= valid_q[i-1];
      end
    end

    // NOTE: payload registers carry no reset; they are only ever consumed
    // when the matching valid bit is set, so only the valids need clearing.
    always_ff @(posedge clk) begin
      a_q[0]      <= in_a;
      b_q[0]      <= in_b;
      golden_q[0] <= in_golden;
      for (int i = 1; i < LAT; i++) begin
        a_q[i]      <= a_q[i-1];
        b_q[i]      <= b_q[i-1];
        golden_q[i] <= golden_q[i-1];
      end
    end

    assign out_valid  = valid_q[LAT-1];
    assign out_a      = a_q[LAT-1];
    assign out_b      = b_q[LAT-1];
    assign out_golden = golden_q[LAT-1];
  end

endmodule

// File: rtl/multiplier_sweep_ctrl.sv
// multiplier_sweep_ctrl
// Exhaustive scoring engine for one candidate N-bit multiplier. A start
// request sweeps all 2^(2N) operand pairs into the candidate, compares each
// product with a latency-matched golden A*B and counts mismatches.
// Optional first-failure capture: define MULT_SWEEP_FIRST_FAIL_EN.
// Ports:
//   clk, rst_n       : clock, asynchronous active-low reset
//   start, abort     : run request / cancel (abort wins over start)
//   busy, done, pass : status (busy in ISSUE/DRAIN, done in DONE,
//                      pass = no mismatches while done)
//   err_count        : mismatch count of the current or last run
//   mul_a, mul_b     : operands driven to the candidate
//   mul_p            : candidate product
//   fail_valid/a/b/p : first mismatch capture (zero when capture disabled)
module multiplier_sweep_ctrl
  import multiplier_eval_pkg::*;
#(
  parameter int N   = 2,
  parameter int LAT = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      abort,
  output logic                      busy,
  output logic                      done,
  output logic                      pass,
  output logic [count_width(N)-1:0] err_count,
  output logic [N-1:0]              mul_a,
  output logic [N-1:0]              mul_b,
  input  logic [prod_width(N)-1:0]  mul_p,
  output logic                      fail_valid,
  output logic [N-1:0]              fail_a,
  output logic [N-1:0]              fail_b,
  output logic [prod_width(N)-1:0]  fail_p
);

  localparam int PW = prod_width(N);

  sweep_state_t  state, state_next;
  logic [PW-1:0] k;
  logic [2:0]    drain_cnt;
  logic          accept_start;
  logic          last_vec;
  logic          drain_last;
  logic          mismatch;

  logic          dl_valid;
  logic [N-1:0]  dl_a;
  logic [N-1:0]  dl_b;
  logic [PW-1:0] dl_golden;
  logic [PW-1:0] golden;

  assign accept_start = start && !abort && (state == IDLE || state == DONE);
  assign last_vec     = (k == '1);
  assign drain_last   = (drain_cnt == 3'(LAT - 1));

  // The operand registers are the two halves of the vector counter; k is
  // cleared on every path into IDLE and held through DRAIN and DONE.
  assign mul_a = k[N-1:0];
  assign mul_b = k[PW-1:N];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: every output of this block gets a default first so no path
  // through the case leaves it unassigned and infers a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:  if (start)      state_next = ISSUE;
      ISSUE: if (last_vec)   state_next = (LAT > 0) ? DRAIN : DONE;
      DRAIN: if (drain_last) state_next = DONE;
      DONE:  if (start)      state_next = ISSUE;
      default:               state_next = IDLE;
    endcase
    if (abort) state_next = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k         <= '0;
      drain_cnt <= '0;
    end else begin
      if (abort || accept_start)           k <= '0;
      else if (state == ISSUE && !last_vec) k <= k + 1'b1;

      if (state == DRAIN) drain_cnt <= drain_cnt + 3'd1;
      else                drain_cnt <= '0;
    end
  end

  assign golden = {{N{1'b0}}, mul_a} * {{N{1'b0}}, mul_b};

  multiplier_sweep_delay #(
    .N   (N),
    .LAT (LAT)
  ) u_delay (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (abort),
    .in_valid   (state == ISSUE),
    .in_a       (mul_a),
    .in_b       (mul_b),
    .in_golden  (golden),
    .out_valid  (dl_valid),
    .out_a      (dl_a),
    .out_b      (dl_b),
    .out_golden (dl_golden)
  );

  assign mismatch = dl_valid && (mul_p != dl_golden);

  // Count never exceeds 2^(2N), which fits in 2N+1 bits, so no saturation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            err_count <= '0;
    else if (accept_start) err_count <= '0;
    else if (mismatch)     err_count <= err_count + 1'b1;
  end

  assign busy = (state == ISSUE) || (state == DRAIN);
  assign done = (state == DONE);
  assign pass = done && (err_count == '0);

`ifdef MULT_SWEEP_FIRST_FAIL_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fail_valid <= 1'b0;
      fail_a     <= '0;
      fail_b     <= '0;
      fail_p     <= '0;
    end else if (accept_start) begin
      fail_valid <= 1'b0;
      fail_a     <= '0;
      fail_b     <= '0;
      fail_p     <= '0;
    end else if (mismatch && !fail_valid) begin
      fail_valid <= 1'b1;
      fail_a     <= dl_a;
      fail_b     <= dl_b;
      fail_p     <= mul_p;
    end
  end
`else
  assign fail_valid = 1'b0;
  assign fail_a     = '0;
  assign fail_b     = '0;
  assign fail_p     = '0;

  logic unused_capture;
  assign unused_capture = ^{dl_a, dl_b};
`endif

endmodule
